// File: rtl/job_pkg.sv
// Shared definitions for the job manager status-ring writer: record layout,
// fixed AXI attributes and the writer FSM encoding.
package job_pkg;

    localparam int REC_JOB_LSB    = 0;
    localparam int REC_STATUS_LSB = 16;
    localparam int REC_MARKER_LSB = 24;
    localparam int REC_CYCLES_LSB = 32;
    localparam int REC_SEQ_LSB    = 64;
    localparam int REC_USED_BITS  = 96;

    localparam logic [7:0] REC_MARKER = 8'hA5;

    localparam logic [2:0] SIZE_64B   = 3'd6;
    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [3:0] CACHE_NB   = 4'd3;

    // Queue entry is {job_id, status, cycles}
    localparam int CMPL_WIDTH = 56;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    // Only the low 96 bits of a record carry information; the rest is zero.
    function automatic logic [REC_USED_BITS-1:0] build_record(
        input logic [15:0] job_id,
        input logic [7:0]  status,
        input logic [31:0] cycles,
        input logic [31:0] seq
    );
        logic [REC_USED_BITS-1:0] rec;
        rec = '0;
        rec[REC_JOB_LSB    +: 16] = job_id;
        rec[REC_STATUS_LSB +: 8]  = status;
        rec[REC_MARKER_LSB +: 8]  = REC_MARKER;
        rec[REC_CYCLES_LSB +: 32] = cycles;
        rec[REC_SEQ_LSB    +: 32] = seq;
        return rec;
    endfunction

endpackage

// File: rtl/job_cmpl_fifo.sv
// First-word-fall-through completion queue; the head entry is always
// visible on o_data while the queue is not empty.
module job_cmpl_fifo
    import job_pkg::*;
#(
    parameter int WIDTH = CMPL_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // A pop frees a slot in the same cycle, so a full queue may still accept.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_COUNT) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/job_status_writer.sv
// AXI4 write master that posts one 64-byte completion record per finished
// job into a host status ring, strictly in order, one write in flight.
module job_status_writer
    import job_pkg::*;
#(
    parameter int ID_WIDTH     = 1,
    parameter int AWUSER_WIDTH = 8,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 64,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      writer_start,
    input  logic [63:0]               status_base,
    input  logic [15:0]               ring_size,
    input  logic                      cmpl_valid,
    output logic                      cmpl_ready,
    input  logic [15:0]               cmpl_job_id,
    input  logic [7:0]                cmpl_status,
    input  logic [31:0]               cmpl_cycles,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
    output logic [3:0]                m_axi_awcache,
    output logic                      m_axi_awlock,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [31:0]               cmpl_count,
    output logic                      wr_err,
    output logic                      writer_idle
);

    localparam int QAW = $clog2(QUEUE_DEPTH);

    wr_state_t                r_state;
    wr_state_t                w_next_state;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [15:0]              r_size_m1;
    logic [15:0]              r_wr_ptr;
    logic [31:0]              r_seq;
    logic [31:0]              r_count;
    logic                     r_err;
    logic [ADDR_WIDTH-1:0]    r_awaddr;
    logic [REC_USED_BITS-1:0] r_rec;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_aw_done;
    logic                     r_w_done;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_bready;
    logic                     w_aw_fire;
    logic                     w_w_fire;
    logic                     w_b_fire;
    logic [CMPL_WIDTH-1:0]    w_q_data;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [QAW:0]             w_q_count;
    logic                     w_unused_ok;

    assign w_push    = cmpl_valid && cmpl_ready;
    assign w_aw_fire = r_awvalid && m_axi_awready;
    assign w_w_fire  = r_wvalid && m_axi_wready;
    assign w_b_fire  = w_bready && m_axi_bvalid;

    job_cmpl_fifo #(
        .WIDTH (CMPL_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({cmpl_job_id, cmpl_status, cmpl_cycles}),
        .i_pop   (w_pop),
        .o_data  (w_q_data),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A pending writer_start takes priority over popping, so the next
    // record is formatted against the freshly latched base and pointer.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_bready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty && !writer_start) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_bready = 1'b1;
                if (m_axi_bvalid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The first SEND cycle raises the valids; each then drops on its own
    // handshake and is never re-raised for the same record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_size_m1 <= '0;
            r_wr_ptr  <= '0;
            r_seq     <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_awaddr  <= '0;
            r_rec     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && writer_start) begin
                r_base    <= status_base[ADDR_WIDTH-1:0];
                r_size_m1 <= (ring_size == 16'd0) ? 16'd0 : ring_size - 16'd1;
                r_wr_ptr  <= '0;
                r_seq     <= '0;
                r_count   <= '0;
                r_err     <= 1'b0;
            end
            if (w_pop) begin
                r_awaddr  <= r_base + {{(ADDR_WIDTH-22){1'b0}}, r_wr_ptr, 6'b0};
                r_rec     <= build_record(w_q_data[55:40], w_q_data[39:32],
                                          w_q_data[31:0], r_seq);
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == ST_SEND) begin
                if (w_aw_fire) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end else if (!r_aw_done) begin
                    r_awvalid <= 1'b1;
                end
                if (w_w_fire) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end else if (!r_w_done) begin
                    r_wvalid <= 1'b1;
                end
            end
            if (w_b_fire) begin
                r_err    <= r_err || (m_axi_bresp != 2'b00);
                r_count  <= r_count + 32'd1;
                r_seq    <= r_seq + 32'd1;
                r_wr_ptr <= (r_wr_ptr == r_size_m1) ? 16'd0 : r_wr_ptr + 16'd1;
            end
        end
    end

    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = r_awaddr;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = SIZE_64B;
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awuser   = '0;
    assign m_axi_awcache  = CACHE_NB;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awvalid  = r_awvalid;
    assign m_axi_wdata    = {{(DATA_WIDTH-REC_USED_BITS){1'b0}}, r_rec};
    assign m_axi_wstrb    = '1;
    assign m_axi_wlast    = r_wvalid;
    assign m_axi_wvalid   = r_wvalid;
    assign m_axi_bready   = w_bready;

    assign cmpl_ready  = !w_q_full;
    assign cmpl_count  = r_count;
    assign wr_err      = r_err;
    assign writer_idle = (r_state == ST_IDLE) && w_q_empty;

    assign w_unused_ok = &{1'b0, m_axi_bid, w_q_count};

endmodule
